// File: rtl/mips_defs_pkg.sv
// ============================================================================
// Module   : mips_defs (package)
// Brief    : Opcodes, ALU command encodings and field positions for the pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd3,
    OP_AND  = 6'd5,
    OP_OR   = 6'd6,
    OP_NOR  = 6'd7,
    OP_XOR  = 6'd8,
    OP_SLA  = 6'd9,
    OP_SLL  = 6'd10,
    OP_SRA  = 6'd11,
    OP_SRL  = 6'd12,
    OP_ADDI = 6'd32,
    OP_SUBI = 6'd33,
    OP_LD   = 6'd36,
    OP_ST   = 6'd37,
    OP_BEZ  = 6'd40,
    OP_BNE  = 6'd41,
    OP_JMP  = 6'd42
  } opcode_t;

  localparam logic [3:0] c_exe_add = 4'd0;
  localparam logic [3:0] c_exe_sub = 4'd2;
  localparam logic [3:0] c_exe_and = 4'd4;
  localparam logic [3:0] c_exe_or  = 4'd5;
  localparam logic [3:0] c_exe_nor = 4'd6;
  localparam logic [3:0] c_exe_xor = 4'd7;
  localparam logic [3:0] c_exe_sll = 4'd8;
  localparam logic [3:0] c_exe_sra = 4'd9;
  localparam logic [3:0] c_exe_srl = 4'd10;

  localparam int c_op_lsb  = 26;
  localparam int c_a_lsb   = 21;
  localparam int c_b_lsb   = 16;
  localparam int c_c_lsb   = 11;

  localparam logic [31:0] c_nop_instr = 32'h0000_0000;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module   : register_file
// Brief    : 32x32 regfile, two async read ports with write-through, r0 = 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] r_mem [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= 32'd0;
    end else if (we && wa != 5'd0) begin
      r_mem[wa] <= wd;
    end
  end

  // Bypass lets a reader in the writeback cycle see the value being written.
  always_comb begin
    rd1 = 32'd0;
    rd2 = 32'd0;
    if (ra1 != 5'd0) rd1 = (we && wa == ra1) ? wd : r_mem[ra1];
    if (ra2 != 5'd0) rd2 = (we && wa == ra2) ? wd : r_mem[ra2];
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module   : id_stage
// Brief    : IF/ID latch, register file, decode and ID-stage branch resolve.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic [31:0] PC,
  input  logic        stall,
  input  logic        loadForwardStall,
  input  logic        superStall,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic [31:0] id_pc,
  output logic [3:0]  exe_cmd,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        wb_en_out,
  output logic [4:0]  dest,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic        two_src,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [31:0] st_val
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;

  logic [5:0]  w_op;
  logic [4:0]  w_a;
  logic [4:0]  w_b;
  logic [4:0]  w_c;
  logic [31:0] w_sext;
  logic [31:0] w_ra;
  logic [31:0] w_rb;
  logic        w_frz;
  logic        w_bubble;
  logic        w_cond;
  logic        w_wb;
  logic        w_mr;
  logic        w_mw;

  assign w_op   = r_instr[c_op_lsb +: 6];
  assign w_a    = r_instr[c_a_lsb +: 5];
  assign w_b    = r_instr[c_b_lsb +: 5];
  assign w_c    = r_instr[c_c_lsb +: 5];
  assign w_sext = sext16(r_instr[15:0]);

  assign w_frz    = stall | loadForwardStall | superStall;
  assign w_bubble = stall | loadForwardStall;

  register_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (w_a),
    .ra2 (w_b),
    .rd1 (w_ra),
    .rd2 (w_rb),
    .we  (wb_en),
    .wa  (wb_dest),
    .wd  (wb_value)
  );

  always_comb begin
    exe_cmd = c_exe_add;
    dest    = 5'd0;
    src1    = w_a;
    src2    = w_b;
    two_src = 1'b0;
    val1    = w_ra;
    val2    = w_rb;
    st_val  = 32'd0;
    w_wb    = 1'b0;
    w_mr    = 1'b0;
    w_mw    = 1'b0;
    w_cond  = 1'b0;
    case (opcode_t'(w_op))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
      OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
        dest    = w_c;
        two_src = 1'b1;
        w_wb    = 1'b1;
        case (opcode_t'(w_op))
          OP_SUB:         exe_cmd = c_exe_sub;
          OP_AND:         exe_cmd = c_exe_and;
          OP_OR:          exe_cmd = c_exe_or;
          OP_NOR:         exe_cmd = c_exe_nor;
          OP_XOR:         exe_cmd = c_exe_xor;
          OP_SLA, OP_SLL: exe_cmd = c_exe_sll;
          OP_SRA:         exe_cmd = c_exe_sra;
          OP_SRL:         exe_cmd = c_exe_srl;
          default:        exe_cmd = c_exe_add;
        endcase
      end
      OP_ADDI, OP_SUBI, OP_LD: begin
        val2    = w_sext;
        dest    = w_b;
        w_wb    = 1'b1;
        w_mr    = (w_op == OP_LD);
        exe_cmd = (w_op == OP_SUBI) ? c_exe_sub : c_exe_add;
      end
      OP_ST: begin
        val2    = w_sext;
        st_val  = w_rb;
        two_src = 1'b1;
        w_mw    = 1'b1;
      end
      OP_BEZ: w_cond = (w_ra == 32'd0);
      OP_BNE: begin
        w_cond  = (w_ra != w_rb);
        two_src = 1'b1;
      end
      OP_JMP: w_cond = 1'b1;
      default: begin
        src1 = 5'd0;
        src2 = 5'd0;
        val1 = 32'd0;
        val2 = 32'd0;
      end
    endcase
  end

  assign wb_en_out      = w_wb & ~w_bubble;
  assign mem_r_en       = w_mr & ~w_bubble;
  assign mem_w_en       = w_mw & ~w_bubble;
  assign branch_taken   = w_cond & ~w_frz;
  assign branch_address = r_pc + 32'd4 + {w_sext[29:0], 2'b00};
  assign id_pc          = r_pc;

  // Freeze wins over flush so a stalled branch is re-evaluated next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= c_nop_instr;
      r_pc    <= 32'd0;
    end else if (w_frz) begin
      r_instr <= r_instr;
      r_pc    <= r_pc;
    end else if (branch_taken) begin
      r_instr <= c_nop_instr;
      r_pc    <= 32'd0;
    end else begin
      r_instr <= Instruction;
      r_pc    <= PC;
    end
  end

endmodule

`default_nettype wire
